slice_merge_fifo: RTL

SLICE_MERGE_FIFO -- requirements
Module: slice_merge_fifo

---
 rtl/slice_merge_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/slice_merge_fifo.sv
// slice_merge_fifo: merges an upper and a lower field into an 8-bit word and
// buffers the words in a DEPTH-entry FIFO with a valid/ready handshake on both
// sides. Occupancy is exposed on count, and the sticky overrun flag records
// any attempt to push while the FIFO is full.
// Optional feature: define SLICE_MERGE_PARITY_EN to store an even-parity bit
// with each entry and present the head entry's parity on parity_out.
module slice_merge_fifo #(
    parameter int DEPTH = 4,
    parameter int HI_W  = 5,
    parameter int LO_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [HI_W-1:0]          hi_in,
    input  logic [LO_W-1:0]          lo_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
`ifdef SLICE_MERGE_PARITY_EN
    ,
    output logic                     parity_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef SLICE_MERGE_PARITY_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    word;
    logic [EW-1:0] entry_w;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign word = {hi_in, lo_in};
`ifdef SLICE_MERGE_PARITY_EN
    assign entry_w = {^word, word};
`else
    assign entry_w = word;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO refuses the push even when a pop frees a slot in the same
    // cycle, so in_ready depends only on the registered occupancy.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    // Entry storage; contents are never cleared, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_w;
        end
    end

    // Next-state for pointers, occupancy and the sticky overrun flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q | (in_valid & full);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs are decoded from registered state, so reset takes effect on
    // them without waiting for a clock edge.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        in_ready  = !full;
        out_valid = !empty;
        count     = count_q;
        overrun   = overrun_q;
        data_out  = empty ? 8'h00 : head[7:0];
`ifdef SLICE_MERGE_PARITY_EN
        parity_out = empty ? 1'b0 : head[8];
`endif
    end

endmodule
